// File: rtl/dbg_cpu_ctrl.sv
// Debug run-control sequencer: gates the 68k clock enable so the CPU only stops
// between bus cycles, under command from the Avalon-MM debug bridge.
module dbg_cpu_ctrl #(
  parameter int ADDR_W = 24,
  parameter int STEP_W = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [19:0]       avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  input  logic              cpu_as_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_clken,
  output logic              cpu_halted
);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_HALT_PEND = 2'd1,
    S_HALTED    = 2'd2,
    S_STEP      = 2'd3
  } state_t;

  state_t            r_state, w_state_next;
  logic              r_as_d;
  logic              w_st, w_cmp;
  logic [ADDR_W-1:0] r_last_addr, r_brk_addr;
  logic              r_brk_en;
  logic [31:0]       r_cycle_cnt;
  logic [STEP_W-1:0] r_step_count, r_remaining, w_remaining_next;
  logic              r_break_hit, w_break_hit_next;
  logic              r_rd_busy;
  logic [31:0]       r_readdata;
  logic              r_clken, r_halted;
  logic              w_wr_acc, w_rd_acc, w_cmd;
  logic              w_op_halt, w_op_run, w_op_step, w_op_clr, w_brk_match;
  logic [31:0]       w_status, w_brk_rd, w_rd_mux;

  assign w_st  = r_as_d & ~cpu_as_n;
  assign w_cmp = ~r_as_d & cpu_as_n;

  // The single busy cycle after a read accept is also the data-valid cycle.
  assign avs_waitrequest   = r_rd_busy;
  assign avs_readdatavalid = r_rd_busy;
  assign avs_readdata      = r_readdata;
  assign cpu_clken         = r_clken;
  assign cpu_halted        = r_halted;

  assign w_wr_acc  = avs_write & ~r_rd_busy;
  assign w_rd_acc  = avs_read & ~avs_write & ~r_rd_busy;
  assign w_cmd     = w_wr_acc && (avs_address == 20'h00000);
  assign w_op_halt = w_cmd && (avs_writedata[1:0] == 2'd0);
  assign w_op_run  = w_cmd && (avs_writedata[1:0] == 2'd1);
  assign w_op_step = w_cmd && (avs_writedata[1:0] == 2'd2);
  assign w_op_clr  = w_cmd && (avs_writedata[1:0] == 2'd3);
  assign w_brk_match = w_st && r_brk_en && (cpu_addr == r_brk_addr);

  always_comb begin
    w_status        = 32'd0;
    w_status[1:0]   = r_state;
    w_status[4]     = r_break_hit;
    w_status[5]     = cpu_as_n;
    w_status[31:16] = 16'(r_remaining);
    w_brk_rd        = 32'(r_brk_addr) | {r_brk_en, 31'd0};
    case (avs_address)
      20'h00000: w_rd_mux = w_status;
      20'h00004: w_rd_mux = 32'(r_step_count);
      20'h00008: w_rd_mux = w_brk_rd;
      20'h0000C: w_rd_mux = 32'(r_last_addr);
      20'h00010: w_rd_mux = r_cycle_cnt;
      default:   w_rd_mux = 32'hDEADBEEF;
    endcase
  end

  // Commands are checked before bus events so a same-cycle command wins.
  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_break_hit_next = r_break_hit;
    case (r_state)
      S_RUN: begin
        if (w_op_halt) begin
          w_state_next = S_HALT_PEND;
        end else if (w_brk_match) begin
          w_state_next     = S_HALT_PEND;
          w_break_hit_next = 1'b1;
        end
      end
      S_HALT_PEND: begin
        if (w_op_run)  w_state_next = S_RUN;
        else if (w_cmp) w_state_next = S_HALTED;
      end
      S_HALTED: begin
        if (w_op_run) begin
          w_state_next     = S_RUN;
          w_break_hit_next = 1'b0;
        end else if (w_op_step) begin
          w_state_next     = S_STEP;
          w_remaining_next = (r_step_count == '0) ? STEP_W'(1) : r_step_count;
        end
      end
      S_STEP: begin
        if (w_op_halt) begin
          w_state_next = S_HALT_PEND;
        end else if (w_op_run) begin
          w_state_next = S_RUN;
        end else if (w_cmp) begin
          w_remaining_next = r_remaining - STEP_W'(1);
          if (r_remaining == STEP_W'(1)) w_state_next = S_HALTED;
        end
      end
      default: w_state_next = S_RUN;
    endcase
    if (w_op_clr) w_break_hit_next = 1'b0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_remaining <= '0;
      r_break_hit <= 1'b0;
      r_clken     <= 1'b1;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_break_hit <= w_break_hit_next;
      r_clken     <= (w_state_next != S_HALTED);
      r_halted    <= (w_state_next == S_HALTED);
    end
  end

  // as_d resets to the idle (high) level so leaving reset is not seen as a completion.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_as_d       <= 1'b1;
      r_last_addr  <= '0;
      r_cycle_cnt  <= 32'd0;
      r_step_count <= '0;
      r_brk_addr   <= '0;
      r_brk_en     <= 1'b0;
      r_rd_busy    <= 1'b0;
      r_readdata   <= 32'd0;
    end else begin
      r_as_d    <= cpu_as_n;
      r_rd_busy <= w_rd_acc;
      if (w_st)     r_last_addr <= cpu_addr;
      if (w_cmp)    r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_rd_acc) r_readdata  <= w_rd_mux;
      if (w_wr_acc && (avs_address == 20'h00004))
        r_step_count <= avs_writedata[STEP_W-1:0];
      if (w_wr_acc && (avs_address == 20'h00008)) begin
        r_brk_addr <= avs_writedata[ADDR_W-1:0];
        r_brk_en   <= avs_writedata[31];
      end
    end
  end

endmodule

// File: tb/tb_dbg_cpu_ctrl.sv
// Scoreboarded bench for dbg_cpu_ctrl: reads push expected data, a monitor
// pops and checks on every readdatavalid; control outputs are checked inline.
module tb_dbg_cpu_ctrl;
  localparam int ADDR_W = 24;
  localparam int STEP_W = 16;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic [19:0]       avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic              avs_waitrequest;
  logic              cpu_as_n = 1'b1;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              cpu_clken;
  logic              cpu_halted;

  dbg_cpu_ctrl #(.ADDR_W(ADDR_W), .STEP_W(STEP_W)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
    .cpu_as_n(cpu_as_n), .cpu_addr(cpu_addr),
    .cpu_clken(cpu_clken), .cpu_halted(cpu_halted)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    string       nm;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endfunction

  // Monitor: one expected entry per readdatavalid, arriving one clock after accept.
  always @(negedge clk_sys) begin
    if (!reset && avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rdv act=%h req=none", avs_readdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("rd %s data=%h", e.nm, avs_readdata);
        chk(e.nm, avs_readdata, e.data);
        chk({e.nm, "_lat"}, 32'(cyc), 32'(e.cyc + 1));
      end
    end
  end

  task automatic wait_ready(string nm);
    int k = 0;
    @(negedge clk_sys);
    while (avs_waitrequest && k < 10) begin
      @(negedge clk_sys);
      k++;
    end
    if (k >= 10) chk({nm, "_wait_timeout"}, 32'(avs_waitrequest), 32'd0);
  endtask

  task automatic bus_rd(input logic [19:0] a, input logic [31:0] req, input string nm);
    exp_t e;
    wait_ready(nm);
    avs_address = a;
    avs_read    = 1'b1;
    e.data = req;
    e.nm   = nm;
    e.cyc  = cyc;
    exp_q.push_back(e);
    @(posedge clk_sys);
    #1 avs_read = 1'b0;
  endtask

  task automatic bus_wr(input logic [19:0] a, input logic [31:0] d, input logic also_rd);
    wait_ready("wr");
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    avs_read      = also_rd;
    $display("wr addr=%h data=%h rd=%0b", a, d, also_rd);
    @(posedge clk_sys);
    #1;
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  task automatic cpu_cycle(input logic [ADDR_W-1:0] a);
    @(negedge clk_sys);
    cpu_addr = a;
    cpu_as_n = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    cpu_as_n = 1'b1;
    @(negedge clk_sys);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_clken", 32'(cpu_clken), 32'd1);
    chk("rst_halted", 32'(cpu_halted), 32'd0);
    chk("rst_wait", 32'(avs_waitrequest), 32'd0);
    chk("rst_rdv", 32'(avs_readdatavalid), 32'd0);
    bus_rd(20'h00, 32'h0000_0020, "rst_status");
    bus_rd(20'h04, 32'h0, "rst_stepcnt");
    bus_rd(20'h08, 32'h0, "rst_break");
    bus_rd(20'h0C, 32'h0, "rst_lastaddr");
    bus_rd(20'h10, 32'h0, "rst_cycles");

    // Halt requested mid bus cycle: waits for AS_n to rise.
    @(negedge clk_sys);
    cpu_addr = 24'h000100;
    cpu_as_n = 1'b0;
    @(negedge clk_sys);
    bus_wr(20'h00, 32'd0, 1'b0);
    bus_rd(20'h00, 32'h0000_0001, "halt_pend_status");
    @(negedge clk_sys);
    chk("halt_pend_clken", 32'(cpu_clken), 32'd1);
    cpu_as_n = 1'b1;
    @(negedge clk_sys);
    chk("halted_clken", 32'(cpu_clken), 32'd0);
    chk("halted_flag", 32'(cpu_halted), 32'd1);
    bus_rd(20'h00, 32'h0000_0022, "halted_status");
    bus_rd(20'h10, 32'd1, "halt_cycles");
    bus_rd(20'h0C, 32'h100, "halt_lastaddr");

    // Step 3 bus cycles.
    bus_wr(20'h04, 32'd3, 1'b0);
    bus_rd(20'h04, 32'd3, "stepcnt_rb");
    bus_wr(20'h00, 32'd2, 1'b0);
    bus_rd(20'h00, 32'h0003_0023, "step_rem3");
    cpu_cycle(24'h000200);
    bus_rd(20'h00, 32'h0002_0023, "step_rem2");
    cpu_cycle(24'h000204);
    bus_rd(20'h00, 32'h0001_0023, "step_rem1");
    cpu_cycle(24'h000208);
    bus_rd(20'h00, 32'h0000_0022, "step3_done");
    @(negedge clk_sys);
    chk("step3_clken", 32'(cpu_clken), 32'd0);
    bus_rd(20'h10, 32'd4, "step3_cycles");

    // STEP_COUNT of zero steps exactly once.
    bus_wr(20'h04, 32'd0, 1'b0);
    bus_wr(20'h00, 32'd2, 1'b0);
    bus_rd(20'h00, 32'h0001_0023, "step0_rem1");
    cpu_cycle(24'h00020C);
    bus_rd(20'h00, 32'h0000_0022, "step0_done");
    bus_rd(20'h10, 32'd5, "step0_cycles");

    // Breakpoint at 0x400.
    bus_wr(20'h08, 32'h8000_0400, 1'b0);
    bus_rd(20'h08, 32'h8000_0400, "break_rb");
    bus_wr(20'h00, 32'd1, 1'b0);
    bus_rd(20'h00, 32'h0000_0020, "run_status");
    cpu_cycle(24'h0003FC);
    bus_rd(20'h00, 32'h0000_0020, "nobreak_3fc");
    cpu_cycle(24'h000400);
    bus_rd(20'h00, 32'h0000_0032, "break_status");
    bus_rd(20'h0C, 32'h400, "break_lastaddr");
    bus_rd(20'h10, 32'd7, "break_cycles");
    @(negedge clk_sys);
    chk("break_clken", 32'(cpu_clken), 32'd0);
    bus_wr(20'h00, 32'd3, 1'b0);
    bus_rd(20'h00, 32'h0000_0022, "clr_break");
    bus_wr(20'h00, 32'd0, 1'b0);
    bus_rd(20'h00, 32'h0000_0022, "halt_noop");
    bus_wr(20'h00, 32'd1, 1'b0);
    bus_rd(20'h00, 32'h0000_0020, "rerun_status");

    // Unmapped offset and read/write collision.
    bus_rd(20'h14, 32'hDEAD_BEEF, "unmapped_rd");
    bus_wr(20'h14, 32'hFFFF_FFFF, 1'b0);
    bus_rd(20'h04, 32'd0, "unmapped_wr_step");
    bus_rd(20'h08, 32'h8000_0400, "unmapped_wr_break");
    bus_wr(20'h04, 32'd5, 1'b1);
    bus_rd(20'h04, 32'd5, "rdwr_write_applied");

    // Reset in the middle of a step that has a halt pending.
    bus_wr(20'h00, 32'd0, 1'b0);
    cpu_cycle(24'h000500);
    bus_wr(20'h00, 32'd2, 1'b0);
    @(negedge clk_sys);
    cpu_addr = 24'h000600;
    cpu_as_n = 1'b0;
    bus_wr(20'h00, 32'd0, 1'b0);
    bus_rd(20'h00, 32'h0005_0001, "step_halt_pend");
    @(negedge clk_sys);
    chk("step_pend_clken", 32'(cpu_clken), 32'd1);
    @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    chk("arst_clken", 32'(cpu_clken), 32'd1);
    chk("arst_halted", 32'(cpu_halted), 32'd0);
    cpu_as_n = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    bus_rd(20'h00, 32'h0000_0020, "arst_status");
    bus_rd(20'h10, 32'd0, "arst_cycles");
    bus_rd(20'h04, 32'd0, "arst_stepcnt");
    bus_rd(20'h08, 32'd0, "arst_break");

    repeat (3) @(negedge clk_sys);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
